// File: rtl/pwm_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_pkg
//  Purpose  : Shared defaults and types for the multi-channel PWM generator.
//             DEF_WIDTH / DEF_CHANNELS are the default bit width and channel
//             count. dir_e is the counter direction, used only when the
//             PWM_MULTI_CENTER_EN macro selects centre-aligned mode.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_multi_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage : pwm_multi_pkg
`default_nettype wire

// File: rtl/pwm_multi_chan.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_chan
//  Purpose  : One PWM channel. It holds the shadow duty register, the active
//             duty register and the registered comparator output.
//  Ports    : clk, nrst (async, active-high reset)
//             capture - load duty_in into the shadow register
//             commit  - copy the shadow duty into the active duty
//             enable  - output is forced low when deasserted
//             duty_in - offered duty value
//             cnt     - shared frame counter
//             pwm     - registered PWM output
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_chan
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             capture,
    input  logic             commit,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] shd_duty;
    logic [WIDTH-1:0] act_duty;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            shd_duty <= '0;
            act_duty <= '0;
            pwm      <= 1'b0;
        end else begin
            if (capture) begin
                shd_duty <= duty_in;
            end
            if (commit) begin
                act_duty <= shd_duty;
            end
            // A duty above the terminal count never falls below cnt, so it
            // gives a constant high output. A duty of zero gives a constant
            // low output.
            pwm <= enable && (cnt < act_duty);
        end
    end

endmodule : pwm_multi_chan
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi
//  Purpose  : Multi-channel PWM generator with one shared frame counter and a
//             programmable frame length. The period and the per-channel duty
//             values are taken through a ready/valid handshake into shadow
//             registers. They are committed only at a frame boundary, or
//             immediately while the block is disabled.
//  Macro    : PWM_MULTI_CENTER_EN - counter runs up/down (centre-aligned
//             pulses, 2P-cycle frame). When undefined, the counter is an
//             edge-aligned up-counter with a P+1-cycle frame.
//  Ports    : clk, nrst (async, active-high reset)
//             enable      - run counter; low forces idle
//             period      - terminal count P (frame length minus one)
//             duty_i      - packed duties, channel i at [i*WIDTH +: WIDTH]
//             duty_valid  - duty_i and period are offered
//             duty_ready  - shadow registers free
//             pwm_o       - registered PWM outputs
//             frame_start - one-cycle pulse on the first cycle of a frame
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty_i,
    input  logic                      duty_valid,
    output logic                      duty_ready,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      frame_start
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] shd_period;
    logic             pending;
    logic             wrap;
    logic             capture;
    logic             commit;

    assign duty_ready = !pending;
    assign capture    = duty_valid && !pending;
    // A capture and a commit never coincide because capture requires
    // !pending.
    assign commit     = pending && (wrap || !enable);

`ifdef PWM_MULTI_CENTER_EN
    dir_e dir;
    dir_e dir_next;

    // With P=1 the down-leg is empty, so cnt==1 on the up-leg already ends
    // the frame. P=0 degenerates to a boundary every cycle.
    assign wrap = enable && ((act_period == '0) ||
                             ((cnt == ONE) && ((dir == DIR_DOWN) || (act_period == ONE))));

    always_comb begin
        cnt_next = '0;
        dir_next = DIR_UP;
        if (enable && !wrap) begin
            if (dir == DIR_UP) begin
                if (cnt == act_period) begin
                    dir_next = DIR_DOWN;
                    cnt_next = cnt - ONE;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end else begin
                dir_next = DIR_DOWN;
                cnt_next = cnt - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            dir <= DIR_UP;
        end else begin
            dir <= dir_next;
        end
    end
`else
    assign wrap = enable && (cnt == act_period);

    always_comb begin
        cnt_next = '0;
        if (enable && !wrap) begin
            cnt_next = cnt + ONE;
        end
    end
`endif

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            cnt         <= '0;
            act_period  <= '1;
            shd_period  <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            frame_start <= enable && (cnt == '0);
            if (capture) begin
                shd_period <= period;
                pending    <= 1'b1;
            end else if (commit) begin
                act_period <= shd_period;
                pending    <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_multi_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .nrst    (nrst),
            .capture (capture),
            .commit  (commit),
            .enable  (enable),
            .duty_in (duty_i[i*WIDTH +: WIDTH]),
            .cnt     (cnt),
            .pwm     (pwm_o[i])
        );
    end

endmodule : pwm_multi
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_multi
//  Purpose  : Self-checking directed testbench for pwm_multi (WIDTH=8,
//             CHANNELS=2). It runs the edge-aligned scenarios by default, or
//             the centre-aligned scenario when PWM_MULTI_CENTER_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  period = 8'd0;
    logic [15:0] duty_i = 16'd0;
    logic        duty_valid = 1'b0;
    logic        duty_ready;
    logic [1:0]  pwm_o;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    pwm_multi #(
        .WIDTH    (8),
        .CHANNELS (2)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .enable      (enable),
        .period      (period),
        .duty_i      (duty_i),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_o       (pwm_o),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_start is seen. ok=0 if the bound expires.
    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on a frame_start sample. Counts the frame length and the high
    // cycles of each channel up to the next frame_start.
    task automatic measure(output int len, output int hi0, output int hi1);
        len = 0; hi0 = 0; hi1 = 0;
        do begin
            hi0 += int'(pwm_o[0]);
            hi1 += int'(pwm_o[1]);
            len++;
            tick();
        end while (!frame_start && len < 600);
    endtask

    // One handshake cycle. The caller must ensure duty_ready is high.
    task automatic offer(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1);
        period = p; duty_i = {d1, d0}; duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL reset_pwm: got %b expected 00", pwm_o); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", duty_ready); end
        nrst = 1'b0;
    endtask

    task automatic test_default_frame();
        bit ok; int len, h0, h1;
        enable = 1'b1;
        wait_fs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL default_fs_timeout: got none expected frame_start"); end
        measure(len, h0, h1);
        checks++; if (len != 256) begin errors++; $display("FAIL default_len: got %0d expected 256", len); end
        checks++; if (h0 + h1 != 0) begin errors++; $display("FAIL default_pwm_high: got %0d expected 0", h0 + h1); end
    endtask

    task automatic test_handshake();
        bit ok; int len, h0, h1;
        tick(); tick();
        offer(8'd9, 8'd3, 8'd7);
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_low: got %b expected 0", duty_ready); end
        wait_fs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hs_fs_timeout: got none expected frame_start"); end
        checks++; if (pwm_o !== 2'b11) begin errors++; $display("FAIL hs_rise: got %b expected 11", pwm_o); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_back: got %b expected 1", duty_ready); end
        measure(len, h0, h1);
        checks++; if (len != 10) begin errors++; $display("FAIL hs_len: got %0d expected 10", len); end
        checks++; if (h0 != 3) begin errors++; $display("FAIL hs_ch0_high: got %0d expected 3", h0); end
        checks++; if (h1 != 7) begin errors++; $display("FAIL hs_ch1_high: got %0d expected 7", h1); end
    endtask

    task automatic test_ignore_busy();
        bit ok; int len, h0, h1;
        // Accepted, then the same valid is held with different data while busy.
        period = 8'd9; duty_i = {8'd5, 8'd2}; duty_valid = 1'b1;
        tick();
        period = 8'd4; duty_i = {8'd1, 8'd1};
        tick(); tick(); tick();
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", duty_ready); end
        duty_valid = 1'b0;
        wait_fs(ok);
        measure(len, h0, h1);
        checks++; if (len != 10) begin errors++; $display("FAIL busy_len: got %0d expected 10", len); end
        checks++; if (h0 != 2) begin errors++; $display("FAIL busy_ch0_high: got %0d expected 2", h0); end
        checks++; if (h1 != 5) begin errors++; $display("FAIL busy_ch1_high: got %0d expected 5", h1); end
        offer(8'd9, 8'd4, 8'd6);
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL next_ready_low: got %b expected 0", duty_ready); end
        wait_fs(ok);
        measure(len, h0, h1);
        checks++; if (h0 != 4) begin errors++; $display("FAIL next_ch0_high: got %0d expected 4", h0); end
        checks++; if (h1 != 6) begin errors++; $display("FAIL next_ch1_high: got %0d expected 6", h1); end
    endtask

    task automatic test_boundary();
        bit ok; int len, h0, h1;
        offer(8'd9, 8'd0, 8'd12);
        wait_fs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bnd_fs_timeout: got none expected frame_start"); end
        measure(len, h0, h1);
        checks++; if (len != 10) begin errors++; $display("FAIL bnd_len: got %0d expected 10", len); end
        checks++; if (h0 != 0) begin errors++; $display("FAIL bnd_ch0_low: got %0d expected 0", h0); end
        checks++; if (h1 != 10) begin errors++; $display("FAIL bnd_ch1_high: got %0d expected 10", h1); end
    endtask

    task automatic test_enable_drop();
        int len, h0, h1;
        offer(8'd9, 8'd5, 8'd2);
        tick();
        enable = 1'b0;
        tick();
        checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL dis_pwm: got %b expected 00", pwm_o); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL dis_fs: got %b expected 0", frame_start); end
        tick();
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL dis_ready: got %b expected 1", duty_ready); end
        enable = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reen_fs: got %b expected 1", frame_start); end
        checks++; if (pwm_o !== 2'b11) begin errors++; $display("FAIL reen_pwm: got %b expected 11", pwm_o); end
        measure(len, h0, h1);
        checks++; if (len != 10) begin errors++; $display("FAIL reen_len: got %0d expected 10", len); end
        checks++; if (h0 != 5) begin errors++; $display("FAIL reen_ch0_high: got %0d expected 5", h0); end
        checks++; if (h1 != 2) begin errors++; $display("FAIL reen_ch1_high: got %0d expected 2", h1); end
    endtask

    task automatic test_async_reset();
        bit ok; int len, h0, h1;
        offer(8'd9, 8'd3, 8'd3);
        tick();
        #2 nrst = 1'b1;
        #1;
        checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL arst_pwm: got %b expected 00", pwm_o); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", duty_ready); end
        tick();
        nrst = 1'b0;
        wait_fs(ok);
        measure(len, h0, h1);
        checks++; if (len != 256) begin errors++; $display("FAIL arst_len: got %0d expected 256", len); end
        checks++; if (h0 + h1 != 0) begin errors++; $display("FAIL arst_pwm_high: got %0d expected 0", h0 + h1); end
    endtask

    task automatic test_center();
        bit ok; int len, h0, h1;
        enable = 1'b1;
        offer(8'd4, 8'd2, 8'd2);
        wait_fs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ctr_fs_timeout: got none expected frame_start"); end
        checks++; if (pwm_o !== 2'b11) begin errors++; $display("FAIL ctr_centre: got %b expected 11", pwm_o); end
        measure(len, h0, h1);
        checks++; if (len != 8) begin errors++; $display("FAIL ctr_len: got %0d expected 8", len); end
        checks++; if (h0 != 3) begin errors++; $display("FAIL ctr_ch0_high: got %0d expected 3", h0); end
        checks++; if (h1 != 3) begin errors++; $display("FAIL ctr_ch1_high: got %0d expected 3", h1); end
    endtask

    initial begin
        test_reset();
`ifdef PWM_MULTI_CENTER_EN
        test_center();
`else
        test_default_frame();
        test_handshake();
        test_ignore_busy();
        test_boundary();
        test_enable_drop();
        test_async_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pwm_multi
`default_nettype wire
